// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus/address widths, loader state encoding and the
// sequencer control-word bit positions of the memory strobes.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_LOAD = 2'd1;
  localparam logic [1:0] LD_DONE = 2'd2;

  localparam int MAR_ADDR_LOAD_N = 11;
  localparam int MAR_MEM_LOAD_N  = 10;
  localparam int RAM_EN_N        = 9;
  localparam int RAM_LOAD_N      = 8;

endpackage

// File: rtl/prog_loader.sv
// Streaming program loader: writes 2**ADDR_W bytes into RAM, one per cycle when prog_valid.
// Zero-latency accept; prog_ready is high for the whole LOAD state, so the source paces the load.
module prog_loader #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              cpu_hold,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data
);
  import cpu_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      LD_LOAD: begin
        if (prog_valid) begin
          // Pointer wraps to 0 naturally on the last byte.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == '1) state_d = LD_DONE;
        end
      end
      default: begin
        if (prog_start) begin
          state_d = LD_LOAD;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign prog_ready = (state_q == LD_LOAD);
  assign cpu_hold   = (state_q == LD_LOAD);
  assign prog_done  = (state_q == LD_DONE);
  assign ld_we      = prog_ready && prog_valid;
  assign ld_addr    = ptr_q;
  assign ld_data    = prog_data;

endmodule

// File: rtl/memory_unit.sv
// Memory stage: MAR, MDR and 16x8 RAM with combinational bus read and a program loader.
// Reads are 0-cycle from MAR; CPU strobes are ignored while the loader holds the CPU.
module memory_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              cpu_hold
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              cpu_act;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_loader (
    .clk        (clk),
    .reset      (reset),
    .prog_start (prog_start),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .cpu_hold   (cpu_hold),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  assign cpu_act = !cpu_hold;

  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (cpu_act && !mar_addr_load_n) mar_d = bus_in[ADDR_W-1:0];
    if (cpu_act && !mar_mem_load_n)  mdr_d = bus_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  // Write port uses pre-edge MAR/MDR, so same-cycle loads hit the old address with old data.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = mar_q;
    mem_wdata = mdr_q;
    if (ld_we) begin
      mem_we    = !reset;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else if (cpu_act && !ram_load_n) begin
      mem_we = !reset;
    end
  end

  // No reset: RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus_oe  = cpu_act && !ram_en_n;
  assign bus_out = bus_oe ? mem[mar_q] : '0;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: loader fill, backpressure, CPU path, hazards, reset mid-load.
module tb_memory_unit;

  logic       clk;
  logic       reset;
  logic [7:0] bus_in;
  logic       mar_addr_load_n;
  logic       mar_mem_load_n;
  logic       ram_en_n;
  logic       ram_load_n;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       prog_start;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       prog_ready;
  logic       prog_done;
  logic       cpu_hold;

  int checks;
  int failures;

  memory_unit dut (
    .clk             (clk),
    .reset           (reset),
    .bus_in          (bus_in),
    .mar_addr_load_n (mar_addr_load_n),
    .mar_mem_load_n  (mar_mem_load_n),
    .ram_en_n        (ram_en_n),
    .ram_load_n      (ram_load_n),
    .bus_out         (bus_out),
    .bus_oe          (bus_oe),
    .prog_start      (prog_start),
    .prog_data       (prog_data),
    .prog_valid      (prog_valid),
    .prog_ready      (prog_ready),
    .prog_done       (prog_done),
    .cpu_hold        (cpu_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    bus_in = {4'h0, a};
    mar_addr_load_n = 1'b0;
    tick();
    mar_addr_load_n = 1'b1;
    bus_in = 8'h00;
    ram_en_n = 1'b0;
    #1;
    d = bus_out;
    ram_en_n = 1'b1;
    #1;
  endtask

  task automatic set_mar(input logic [7:0] v);
    bus_in = v;
    mar_addr_load_n = 1'b0;
    tick();
    mar_addr_load_n = 1'b1;
  endtask

  task automatic set_mdr(input logic [7:0] v);
    bus_in = v;
    mar_mem_load_n = 1'b0;
    tick();
    mar_mem_load_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (prog_ready !== 1'b0) begin failures++; $display("FAIL reset_prog_ready got=%b exp=0", prog_ready); end
    checks++; if (prog_done !== 1'b0) begin failures++; $display("FAIL reset_prog_done got=%b exp=0", prog_done); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_cpu_hold got=%b exp=0", cpu_hold); end
    checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL reset_bus_oe got=%b exp=0", bus_oe); end
    checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus_out got=%h exp=00", bus_out); end
  endtask

  task automatic test_loader_fill();
    logic [7:0] d;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL fill_cpu_hold got=%b exp=1", cpu_hold); end
    for (int i = 0; i < 16; i++) begin
      prog_data  = 8'h10 + 8'(i);
      prog_valid = 1'b1;
      #1;
      checks++; if (prog_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, prog_ready); end
      tick();
    end
    prog_valid = 1'b0;
    #1;
    checks++; if (prog_done !== 1'b1) begin failures++; $display("FAIL fill_done got=%b exp=1", prog_done); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL fill_hold_after got=%b exp=0", cpu_hold); end
    checks++; if (prog_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_after got=%b exp=0", prog_ready); end
    for (int i = 0; i < 16; i++) begin
      cpu_read(4'(i), d);
      checks++; if (d !== 8'h10 + 8'(i)) begin failures++; $display("FAIL fill_read[%0d] got=%h exp=%h", i, d, 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int acc;
    logic early_done;
    acc = 0;
    early_done = 1'b0;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    #1;
    checks++; if (prog_done !== 1'b0) begin failures++; $display("FAIL bp_restart_done got=%b exp=0", prog_done); end
    for (int c = 0; c < 32; c++) begin
      prog_valid = c[0];
      prog_data  = 8'hA0 + 8'(acc);
      #1;
      if (prog_done !== 1'b0) early_done = 1'b1;
      if (prog_valid && prog_ready) acc++;
      tick();
    end
    prog_valid = 1'b0;
    #1;
    checks++; if (early_done !== 1'b0) begin failures++; $display("FAIL bp_early_done got=%b exp=0", early_done); end
    checks++; if (acc != 16) begin failures++; $display("FAIL bp_accepts got=%0d exp=16", acc); end
    checks++; if (prog_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", prog_done); end
    prog_valid = 1'b1;
    prog_data  = 8'hEE;
    tick();
    prog_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cpu_read(4'(i), d);
      checks++; if (d !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL bp_read[%0d] got=%h exp=%h", i, d, 8'hA0 + 8'(i)); end
    end
  endtask

  task automatic test_sta();
    set_mar(8'h0A);
    set_mdr(8'h5C);
    ram_load_n = 1'b0;
    tick();
    ram_load_n = 1'b1;
    ram_en_n = 1'b0;
    #1;
    checks++; if (bus_out !== 8'h5C) begin failures++; $display("FAIL sta_bus_out got=%h exp=5c", bus_out); end
    checks++; if (bus_oe !== 1'b1) begin failures++; $display("FAIL sta_bus_oe got=%b exp=1", bus_oe); end
    ram_en_n = 1'b1;
    #1;
    checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL sta_oe_off got=%b exp=0", bus_oe); end
    checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL sta_out_off got=%h exp=00", bus_out); end
    set_mar(8'hFA);
    ram_en_n = 1'b0;
    #1;
    checks++; if (bus_out !== 8'h5C) begin failures++; $display("FAIL sta_upper_bits got=%h exp=5c", bus_out); end
    ram_en_n = 1'b1;
  endtask

  task automatic test_hazard();
    logic [7:0] d;
    set_mar(8'h03);
    set_mdr(8'h77);
    bus_in = 8'h09;
    mar_addr_load_n = 1'b0;
    ram_load_n = 1'b0;
    tick();
    mar_addr_load_n = 1'b1;
    ram_load_n = 1'b1;
    cpu_read(4'h3, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL hz_mar_old_addr got=%h exp=77", d); end
    cpu_read(4'h9, d);
    checks++; if (d !== 8'hA9) begin failures++; $display("FAIL hz_mar_new_untouched got=%h exp=a9", d); end
    set_mar(8'h05);
    bus_in = 8'h88;
    mar_mem_load_n = 1'b0;
    ram_load_n = 1'b0;
    tick();
    mar_mem_load_n = 1'b1;
    ram_load_n = 1'b1;
    cpu_read(4'h5, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL hz_mdr_old_data got=%h exp=77", d); end
    set_mar(8'h06);
    ram_en_n = 1'b0;
    ram_load_n = 1'b0;
    #1;
    checks++; if (bus_out !== 8'hA6) begin failures++; $display("FAIL hz_rw_pre got=%h exp=a6", bus_out); end
    tick();
    ram_en_n = 1'b1;
    ram_load_n = 1'b1;
    cpu_read(4'h6, d);
    checks++; if (d !== 8'h88) begin failures++; $display("FAIL hz_rw_post got=%h exp=88", d); end
  endtask

  task automatic test_load_reset();
    logic [7:0] d;
    set_mar(8'h07);
    set_mdr(8'h99);
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prog_data  = 8'hC0 + 8'(i);
      prog_valid = 1'b1;
      tick();
    end
    prog_valid = 1'b0;
    bus_in = 8'h0C;
    mar_addr_load_n = 1'b0;
    ram_en_n = 1'b0;
    ram_load_n = 1'b0;
    #1;
    checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL ld_cpu_oe got=%b exp=0", bus_oe); end
    checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL ld_cpu_out got=%h exp=00", bus_out); end
    tick();
    mar_addr_load_n = 1'b1;
    ram_en_n = 1'b1;
    ram_load_n = 1'b1;
    bus_in = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (prog_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", prog_ready); end
    checks++; if (prog_done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", prog_done); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL mid_reset_hold got=%b exp=0", cpu_hold); end
    for (int i = 0; i < 5; i++) begin
      cpu_read(4'(i), d);
      checks++; if (d !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL mid_reset_keep[%0d] got=%h exp=%h", i, d, 8'hC0 + 8'(i)); end
    end
    cpu_read(4'h5, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL mid_reset_tail got=%h exp=77", d); end
    cpu_read(4'h7, d);
    checks++; if (d !== 8'hA7) begin failures++; $display("FAIL ld_cpu_write_blocked got=%h exp=a7", d); end
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    prog_data  = 8'hD0;
    prog_valid = 1'b1;
    tick();
    prog_valid = 1'b0;
    #1;
    checks++; if (prog_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", prog_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_read(4'h0, d);
    checks++; if (d !== 8'hD0) begin failures++; $display("FAIL restart_addr0 got=%h exp=d0", d); end
    cpu_read(4'h1, d);
    checks++; if (d !== 8'hC1) begin failures++; $display("FAIL restart_addr1 got=%h exp=c1", d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus_in = 8'h00;
    mar_addr_load_n = 1'b1;
    mar_mem_load_n = 1'b1;
    ram_en_n = 1'b1;
    ram_load_n = 1'b1;
    prog_start = 1'b0;
    prog_data = 8'h00;
    prog_valid = 1'b0;
    test_reset();
    test_loader_fill();
    test_backpressure();
    test_sta();
    test_hazard();
    test_load_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Memory stage directly downstream of the control sequencer. It consumes the four memory control strobes: MAR address load, MAR data load, RAM enable and RAM load.
- Contains the memory address register (MAR), the memory data register (MDR) and a 16x8 program/data RAM.
- Includes a streaming program loader that fills the RAM over a valid/ready handshake before the CPU runs.
- Reads are combinational onto the shared bus. All state updates occur on the rising clock edge, half a cycle after the sequencer's falling-edge strobe update.

Parameters:
- ADDR_W, 4, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, bus and RAM word width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous reset, active-high.
- bus_in  in  DATA_W  shared bus value as seen by this stage.
- mar_addr_load_n  in  1  active-low; load MAR from bus_in[ADDR_W-1:0].
- mar_mem_load_n  in  1  active-low; load MDR from bus_in.
- ram_en_n  in  1  active-low; drive mem[MAR] onto bus_out.
- ram_load_n  in  1  active-low; write MDR into mem[MAR].
- bus_out  out  DATA_W  RAM read data; 0 when not driving.
- bus_oe  out  1  high while this block drives the bus.
- prog_start  in  1  one-cycle pulse; begin a program load.
- prog_data  in  DATA_W  loader byte.
- prog_valid  in  1  prog_data valid.
- prog_ready  out  1  loader accepts a byte this cycle.
- prog_done  out  1  a full 2**ADDR_W-byte load has completed.
- cpu_hold  out  1  high during load; the CPU must not advance.

Behaviour:
- Reset values:
  - MAR=0, MDR=0, loader state IDLE, load pointer=0.
  - prog_ready=0, prog_done=0, cpu_hold=0, bus_oe=0, bus_out=0.
  - RAM contents are NOT cleared by reset.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + prog_start -> LOAD, pointer <= 0, prog_done <= 0.
  - LOAD: prog_ready=1 and cpu_hold=1, both combinational from state.
  - LOAD, on prog_valid && prog_ready: mem[pointer] <= prog_data, pointer <= pointer+1.
  - LOAD, accepting at pointer == 2**ADDR_W-1: go to DONE, pointer wraps to 0.
  - DONE: prog_done=1 and held; prog_ready=0.
  - prog_start while in LOAD is ignored.
  - prog_valid outside LOAD is ignored.
- CPU path:
  - Active only in IDLE/DONE. In LOAD, all four strobes are ignored and bus_oe=0.
  - !mar_addr_load_n: MAR <= bus_in[ADDR_W-1:0]; upper bus bits are discarded.
  - !mar_mem_load_n: MDR <= bus_in.
  - !ram_load_n: mem[MAR] <= MDR, using pre-edge MAR and MDR values.
  - !ram_en_n: bus_oe=1, bus_out=mem[MAR] combinationally. Otherwise bus_oe=0 and bus_out=0.
  - Read latency is 0 cycles after MAR settles. Write takes effect at the edge and is visible on the following read.
- Simultaneous events:
  - MAR load + RAM write in the same cycle: the write goes to the old address.
  - MDR load + RAM write in the same cycle: the old MDR is written.
  - ram_en_n + ram_load_n both low: bus_out shows the pre-write content during that cycle, and the write still occurs.
- Reset mid-load:
  - FSM returns to IDLE, pointer=0, prog_done=0.
  - Bytes already written remain in RAM.
  - The CPU path is usable from the next cycle.
- Address wrap: MAR is ADDR_W bits, so address 0xF+1 is not representable and no overflow logic is needed.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, loader state encoding, and control-word bit indices matching the sequencer (MAR_ADDR_LOAD_N=11, MAR_MEM_LOAD_N=10, RAM_EN_N=9, RAM_LOAD_N=8).
- One natural sub-module, prog_loader: FSM, pointer, prog_ready/prog_done/cpu_hold. It exports write-enable, address and data to the RAM write port, which is muxed against the CPU write port.

Test Plan:
- Loader fill: reset, pulse prog_start, stream bytes 0x10..0x1F with prog_valid=1 -> prog_ready high for 16 cycles, then prog_done=1 and cpu_hold=0; reading addresses 0..15 returns 0x10..0x1F.
- Backpressure: toggle prog_valid every other cycle -> exactly 16 accepted writes; pointer advances only on valid&&ready; prog_done asserts after the 16th.
- STA sequence: bus_in=0x0A with mar_addr_load_n=0; then bus_in=0x5C with mar_mem_load_n=0; then ram_load_n=0 -> a subsequent ram_en_n=0 gives bus_out=0x5C and bus_oe=1.
- Same-cycle hazard: MAR=3 and MDR=0x77, then assert mar_addr_load_n=0 with bus_in=0x09 together with ram_load_n=0 -> mem[3]=0x77, mem[9] unchanged.
- Read during load: in LOAD, assert ram_en_n=0 and ram_load_n=0 -> bus_oe=0 and RAM unchanged by the CPU path.
- Reset mid-load: assert reset after 5 bytes -> prog_ready=0, prog_done=0, cpu_hold=0, mem[0..4] retained; a new prog_start restarts at address 0.
